exu_wbck_arb: RTL and testbench
===============================

EXU_WBCK_ARB -- requirements
Module: exu_wbck_arb

Interface
REQ-001 Parameter XLEN, default 32, data width of write-back values.
REQ-002 Parameter RFIDX_W, default 5, register-index width.
REQ-003 Parameter LP_DEPTH, default 2, long-pipe write-back FIFO depth (power of two, >=2).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 alu_wbck_i_valid  in  1  ALU result valid.
REQ-007 alu_wbck_i_ready  out  1  ALU result accepted this cycle.
REQ-008 alu_wbck_i_wdat  in  XLEN  ALU result data.
REQ-009 alu_wbck_i_rdidx  in  RFIDX_W  ALU destination index.
REQ-010 longp_wbck_i_valid  in  1  long-pipe (LSU/MDV) result valid.
REQ-011 longp_wbck_i_ready  out  1  long-pipe result accepted into FIFO.
REQ-012 longp_wbck_i_wdat  in  XLEN  long-pipe result data.
REQ-013 longp_wbck_i_rdidx  in  RFIDX_W  long-pipe destination index.
REQ-014 longp_wbck_i_err  in  1  long-pipe result is an exception, no register write.
REQ-015 rf_wbck_o_ena  out  1  register-file write enable.
REQ-016 rf_wbck_o_wdat  out  XLEN  register-file write data.
REQ-017 rf_wbck_o_rdidx  out  RFIDX_W  register-file write index.
REQ-018 longp_err_o  out  1  one-cycle pulse when an err entry retires.
REQ-019 longp_pend_o  out  1  FIFO non-empty.
REQ-020 lp_cnt_o  out  clog2(LP_DEPTH)+1  current FIFO occupancy.

Function
REQ-021 At most one register-file write per cycle; outputs rf_wbck_o_* are combinational from the selected source.
REQ-022 Long-pipe results always enter the FIFO; earliest retirement is the cycle after acceptance (no bypass).
REQ-023 longp_wbck_i_ready = (lp_cnt < LP_DEPTH), independent of pops in the same cycle; push when valid & ready.
REQ-024 Priority: FIFO head retires whenever FIFO non-empty; ALU retires only when FIFO empty.
REQ-025 alu_wbck_i_ready = (lp_cnt == 0), from registered count; ALU write occurs when valid & ready.
REQ-026 Head retire: pop every cycle FIFO non-empty; rf_wbck_o_ena = ~err & (rdidx != 0); longp_err_o = err.
REQ-027 ALU retire: rf_wbck_o_ena = (alu_rdidx != 0); writes to index 0 never assert ena.
REQ-028 No source selected: rf_wbck_o_ena=0, wdat/rdidx=0, longp_err_o=0.
REQ-029 Simultaneous push and pop: count unchanged, data order preserved; pointers wrap modulo LP_DEPTH.
REQ-030 Push while full is impossible (ready=0); an ALU valid held while FIFO drains retires in the first cycle count is 0.
REQ-031 FIFO strictly in-order; entries retire in acceptance order.
REQ-032 No combinational path from alu_wbck_i_valid or longp_wbck_i_valid to either ready output.

Reset
REQ-033 While rst high: pointers=0, lp_cnt_o=0, longp_pend_o=0, rf_wbck_o_ena=0, longp_err_o=0, longp_wbck_i_ready=1, alu_wbck_i_ready=1.
REQ-034 Reset asserted mid-operation discards all FIFO entries immediately; no write issued for discarded entries.
REQ-035 FIFO data storage needs no reset; only control state resets.

Verification
REQ-036 ALU only: alu valid, rdidx=5, wdat=0xDEADBEEF, FIFO empty -> same cycle ena=1, rdidx=5, wdat=0xDEADBEEF, ready=1.
REQ-037 Priority: longp push rdidx=3 wdat=0x11 at cycle N, ALU valid rdidx=4 from N -> cycle N+1 writes x3=0x11, ALU ready=0; cycle N+2 writes x4, ALU ready=1.
REQ-038 Full: 3 consecutive longp valids, LP_DEPTH=2, no drain stall -> pushes at N, N+1 (pop N+1), ready stays 1 since count<=1; with ALU irrelevant, lp_cnt_o never exceeds 2 and longp ready=0 only when count==2.
REQ-039 Error: longp push err=1 rdidx=7 -> next cycle ena=0, longp_err_o=1 for exactly one cycle, lp_cnt returns to 0.
REQ-040 x0: ALU rdidx=0 wdat=0x5 -> ena=0, ready=1, no state change.
REQ-041 Reset mid-flight: 2 entries queued, rst pulsed -> lp_cnt_o=0, longp_pend_o=0, no writes after release until new push.

Source files
------------

// File: rtl/exu_wbck_arb.sv
// Write-back arbiter: merges single-cycle ALU results with long-pipe results
// buffered in a small in-order FIFO onto the single register-file write port.
module exu_wbck_arb #(
    parameter int XLEN     = 32,
    parameter int RFIDX_W  = 5,
    parameter int LP_DEPTH = 2,
    localparam int PTR_W   = (LP_DEPTH > 1) ? $clog2(LP_DEPTH) : 1,
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               alu_wbck_i_valid,
    output logic               alu_wbck_i_ready,
    input  logic [XLEN-1:0]    alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,

    input  logic               longp_wbck_i_valid,
    output logic               longp_wbck_i_ready,
    input  logic [XLEN-1:0]    longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
    input  logic               longp_wbck_i_err,

    output logic               rf_wbck_o_ena,
    output logic [XLEN-1:0]    rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,

    output logic               longp_err_o,
    output logic               longp_pend_o,
    output logic [CNT_W-1:0]   lp_cnt_o
);

    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(LP_DEPTH);
    localparam logic [RFIDX_W-1:0] X0_C    = '0;

    logic [XLEN-1:0]    r_fifo_wdat  [LP_DEPTH];
    logic [RFIDX_W-1:0] r_fifo_rdidx [LP_DEPTH];
    logic               r_fifo_err   [LP_DEPTH];

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_alu_sel;
    logic [XLEN-1:0]    w_head_wdat;
    logic [RFIDX_W-1:0] w_head_rdidx;
    logic               w_head_err;

    // Both readies come only from the registered count, never from a valid.
    assign longp_wbck_i_ready = (r_cnt < DEPTH_C);
    assign alu_wbck_i_ready   = (r_cnt == '0);

    assign w_push    = longp_wbck_i_valid & longp_wbck_i_ready;
    assign w_pop     = (r_cnt != '0);
    // Reset gates the ALU write so nothing reaches the register file while rst is high.
    assign w_alu_sel = alu_wbck_i_valid & alu_wbck_i_ready & ~rst;

    assign w_head_wdat  = r_fifo_wdat[r_rptr];
    assign w_head_rdidx = r_fifo_rdidx[r_rptr];
    assign w_head_err   = r_fifo_err[r_rptr];

    assign longp_pend_o = w_pop;
    assign lp_cnt_o     = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wdat[r_wptr]  <= longp_wbck_i_wdat;
            r_fifo_rdidx[r_wptr] <= longp_wbck_i_rdidx;
            r_fifo_err[r_wptr]   <= longp_wbck_i_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        rf_wbck_o_ena   = 1'b0;
        rf_wbck_o_wdat  = '0;
        rf_wbck_o_rdidx = '0;
        longp_err_o     = 1'b0;
        if (w_pop) begin
            rf_wbck_o_ena   = ~w_head_err & (w_head_rdidx != X0_C);
            rf_wbck_o_wdat  = w_head_wdat;
            rf_wbck_o_rdidx = w_head_rdidx;
            longp_err_o     = w_head_err;
        end else if (w_alu_sel) begin
            rf_wbck_o_ena   = (alu_wbck_i_rdidx != X0_C);
            rf_wbck_o_wdat  = alu_wbck_i_wdat;
            rf_wbck_o_rdidx = alu_wbck_i_rdidx;
        end
    end

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Bench for exu_wbck_arb: directed scenarios, then randomized traffic checked
// against a queue of expected retirements.
module tb_exu_wbck_arb;

    localparam int XLEN     = 32;
    localparam int RFIDX_W  = 5;
    localparam int LP_DEPTH = 2;

    typedef struct packed {
        logic               err;
        logic [RFIDX_W-1:0] idx;
        logic [XLEN-1:0]    dat;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_v = 1'b0;
    logic               alu_rdy;
    logic [XLEN-1:0]    alu_dat = '0;
    logic [RFIDX_W-1:0] alu_rd = '0;
    logic               lp_v = 1'b0;
    logic               lp_rdy;
    logic [XLEN-1:0]    lp_dat = '0;
    logic [RFIDX_W-1:0] lp_rd = '0;
    logic               lp_err = 1'b0;
    logic               ena;
    logic [XLEN-1:0]    wdat;
    logic [RFIDX_W-1:0] rdidx;
    logic               err_o;
    logic               pend;
    logic [1:0]         cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t mq[$];
    ent_t sb[$];

    always #5 clk = ~clk;

    exu_wbck_arb #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .LP_DEPTH(LP_DEPTH)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .alu_wbck_i_valid   (alu_v),
        .alu_wbck_i_ready   (alu_rdy),
        .alu_wbck_i_wdat    (alu_dat),
        .alu_wbck_i_rdidx   (alu_rd),
        .longp_wbck_i_valid (lp_v),
        .longp_wbck_i_ready (lp_rdy),
        .longp_wbck_i_wdat  (lp_dat),
        .longp_wbck_i_rdidx (lp_rd),
        .longp_wbck_i_err   (lp_err),
        .rf_wbck_o_ena      (ena),
        .rf_wbck_o_wdat     (wdat),
        .rf_wbck_o_rdidx    (rdidx),
        .longp_err_o        (err_o),
        .longp_pend_o       (pend),
        .lp_cnt_o           (cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        ent_t e;
        bit   ahold;
        bit   sel_none;
        int   exp_cnt;

        // Reset state, with an ALU request present that must not write.
        alu_v   = 1'b1;
        alu_rd  = 5'd5;
        alu_dat = 32'hDEADBEEF;
        @(negedge clk); #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_pend", pend, 0);
        chk("rst_ena", ena, 0);
        chk("rst_err", err_o, 0);
        chk("rst_lrdy", lp_rdy, 1);
        chk("rst_ardy", alu_rdy, 1);
        @(negedge clk);
        rst   = 1'b0;
        alu_v = 1'b0;

        // ALU only
        @(negedge clk);
        alu_v = 1'b1; alu_rd = 5'd5; alu_dat = 32'hDEADBEEF;
        #1;
        chk("alu_ena", ena, 1);
        chk("alu_idx", rdidx, 5);
        chk("alu_dat", wdat, 32'hDEADBEEF);
        chk("alu_rdy", alu_rdy, 1);
        chk("alu_err", err_o, 0);

        // Write to x0 is dropped
        @(negedge clk);
        alu_rd = 5'd0; alu_dat = 32'h5;
        #1;
        chk("x0_ena", ena, 0);
        chk("x0_rdy", alu_rdy, 1);
        @(negedge clk);
        alu_v = 1'b0;
        #1;
        chk("x0_cnt", cnt, 0);
        chk("idle_ena", ena, 0);
        chk("idle_out", {rdidx, wdat}, 0);

        // Long-pipe priority over ALU, no bypass
        @(negedge clk);
        lp_v = 1'b1; lp_rd = 5'd3; lp_dat = 32'h11; lp_err = 1'b0;
        #1;
        chk("pri_nobyp", ena, 0);
        chk("pri_lrdy", lp_rdy, 1);
        @(negedge clk);
        lp_v = 1'b0;
        alu_v = 1'b1; alu_rd = 5'd4; alu_dat = 32'h44;
        #1;
        chk("pri_n1_ena", ena, 1);
        chk("pri_n1_idx", rdidx, 3);
        chk("pri_n1_dat", wdat, 32'h11);
        chk("pri_n1_ardy", alu_rdy, 0);
        chk("pri_n1_cnt", cnt, 1);
        chk("pri_n1_pend", pend, 1);
        @(negedge clk); #1;
        chk("pri_n2_ena", ena, 1);
        chk("pri_n2_idx", rdidx, 4);
        chk("pri_n2_dat", wdat, 32'h44);
        chk("pri_n2_ardy", alu_rdy, 1);
        chk("pri_n2_cnt", cnt, 0);
        @(negedge clk);
        alu_v = 1'b0;

        // Three back-to-back long-pipe pushes: count stays <= 1, ready stays high
        for (int i = 0; i < 3; i++) begin
            lp_v = 1'b1; lp_rd = 5'(8 + i); lp_dat = 32'h100 + 32'(i); lp_err = 1'b0;
            #1;
            chk("b2b_lrdy", lp_rdy, 1);
            chk("b2b_cnt", cnt, (i == 0) ? 0 : 1);
            if (i > 0) begin
                chk("b2b_ena", ena, 1);
                chk("b2b_idx", rdidx, 8 + i - 1);
            end
            @(negedge clk);
        end
        lp_v = 1'b0;
        #1;
        chk("b2b_last_idx", rdidx, 10);
        chk("b2b_last_dat", wdat, 32'h102);
        @(negedge clk); #1;
        chk("b2b_drained", cnt, 0);

        // Error entry retires without a write and pulses the error for one cycle
        @(negedge clk);
        lp_v = 1'b1; lp_rd = 5'd7; lp_dat = 32'h77; lp_err = 1'b1;
        #1;
        chk("err_n0", err_o, 0);
        @(negedge clk);
        lp_v = 1'b0; lp_err = 1'b0;
        #1;
        chk("err_ena", ena, 0);
        chk("err_pulse", err_o, 1);
        chk("err_cnt", cnt, 1);
        @(negedge clk); #1;
        chk("err_gone", err_o, 0);
        chk("err_cnt0", cnt, 0);

        // Reset mid-flight discards the queued entry
        @(negedge clk);
        lp_v = 1'b1; lp_rd = 5'd9; lp_dat = 32'h99;
        @(negedge clk);
        lp_rd = 5'd10; lp_dat = 32'hAA;
        #1;
        chk("mrst_idx9", rdidx, 9);
        @(negedge clk);
        lp_v = 1'b0;
        #1;
        chk("mrst_cnt1", cnt, 1);
        rst = 1'b1;
        #1;
        chk("mrst_cnt", cnt, 0);
        chk("mrst_pend", pend, 0);
        chk("mrst_ena", ena, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mrst_quiet_ena", ena, 0);
            chk("mrst_quiet_err", err_o, 0);
            chk("mrst_quiet_cnt", cnt, 0);
        end

        // Randomized traffic against the expected-retirement queue
        ahold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!ahold) begin
                alu_v   = 1'($urandom_range(0, 1));
                alu_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_dat = $urandom;
            end
            lp_v   = ($urandom_range(0, 2) == 0);
            lp_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lp_dat = $urandom;
            lp_err = ($urandom_range(0, 3) == 0);

            exp_cnt  = mq.size();
            sel_none = 1'b0;
            if (mq.size() != 0) begin
                e = mq.pop_front();
                if (e.err || e.idx != 0) sb.push_back(e);
                ahold = alu_v;
            end else if (alu_v) begin
                if (alu_rd != 0) sb.push_back(ent_t'({1'b0, alu_rd, alu_dat}));
                ahold = 1'b0;
            end else begin
                ahold    = 1'b0;
                sel_none = 1'b1;
            end
            if (lp_v && exp_cnt < LP_DEPTH) mq.push_back(ent_t'({lp_err, lp_rd, lp_dat}));

            #1;
            chk("sb_cnt", cnt, exp_cnt);
            chk("sb_pend", pend, exp_cnt != 0);
            chk("sb_ardy", alu_rdy, exp_cnt == 0);
            chk("sb_lrdy", lp_rdy, exp_cnt < LP_DEPTH);
            if (ena || err_o) begin
                if (sb.size() == 0) begin
                    chk("sb_spurious", {ena, err_o}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_idx", rdidx, e.idx);
                    chk("sb_dat", wdat, e.dat);
                    chk("sb_err", err_o, e.err);
                    chk("sb_ena", ena, !e.err);
                end
            end
            chk("sb_missing", sb.size(), 0);
            sb.delete();
            if (sel_none) chk("sb_idle", {rdidx, wdat}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
